// File: rtl/axi_frame_reader_if.sv
// Bus bundle: AXI4 read-address and read-data channels plus the output word stream.
// master = frame reader side; slave = memory / sink side.
interface axi_frame_reader_if #(
   parameter int ID_W     = 1,
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 128,
   parameter int ARUSER_W = 1,
   parameter int RUSER_W  = 1
);
   logic [ID_W-1:0]     M_AXI_ARID;
   logic [ADDR_W-1:0]   M_AXI_ARADDR;
   logic [7:0]          M_AXI_ARLEN;
   logic [2:0]          M_AXI_ARSIZE;
   logic [1:0]          M_AXI_ARBURST;
   logic                M_AXI_ARLOCK;
   logic [3:0]          M_AXI_ARCACHE;
   logic [2:0]          M_AXI_ARPROT;
   logic [3:0]          M_AXI_ARQOS;
   logic [ARUSER_W-1:0] M_AXI_ARUSER;
   logic                M_AXI_ARVALID;
   logic                M_AXI_ARREADY;
   logic [ID_W-1:0]     M_AXI_RID;
   logic [DATA_W-1:0]   M_AXI_RDATA;
   logic [1:0]          M_AXI_RRESP;
   logic                M_AXI_RLAST;
   logic [RUSER_W-1:0]  M_AXI_RUSER;
   logic                M_AXI_RVALID;
   logic                M_AXI_RREADY;
   logic [DATA_W-1:0]   m_data;
   logic                m_valid;
   logic                m_ready;
   logic                m_sof;
   logic                m_eof;

   modport master (
      output M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE,
      output M_AXI_ARBURST, M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT,
      output M_AXI_ARQOS, M_AXI_ARUSER, M_AXI_ARVALID,
      input  M_AXI_ARREADY,
      input  M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST,
      input  M_AXI_RUSER, M_AXI_RVALID,
      output M_AXI_RREADY,
      output m_data, m_valid, m_sof, m_eof,
      input  m_ready
   );

   modport slave (
      input  M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE,
      input  M_AXI_ARBURST, M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT,
      input  M_AXI_ARQOS, M_AXI_ARUSER, M_AXI_ARVALID,
      output M_AXI_ARREADY,
      output M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST,
      output M_AXI_RUSER, M_AXI_RVALID,
      input  M_AXI_RREADY,
      input  m_data, m_valid, m_sof, m_eof,
      output m_ready
   );
endinterface

// File: rtl/axi_frame_reader.sv
// AXI4 read master: fetches one frame in fixed INCR bursts into a staging FIFO
// and streams it out with sof/eof markers.
// Ports: M_AXI_ACLK, M_AXI_ARESETN (sync, low), start/busy/done/err, bus (master).
module axi_frame_reader #(
   parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h10000000,
   parameter int C_M_AXI_BURST_LEN   = 16,
   parameter int C_M_AXI_ID_WIDTH    = 1,
   parameter int C_M_AXI_ADDR_WIDTH  = 32,
   parameter int C_M_AXI_DATA_WIDTH  = 128,
   parameter int C_M_AXI_ARUSER_WIDTH = 1,
   parameter int C_M_AXI_RUSER_WIDTH = 1,
   parameter int FRAME_WORDS         = 518400,
   parameter int FIFO_DEPTH          = 64
) (
   input  logic M_AXI_ACLK,
   input  logic M_AXI_ARESETN,
   input  logic start,
   output logic busy,
   output logic done,
   output logic err,
   axi_frame_reader_if.master bus
);
   localparam int AW_ = C_M_AXI_ADDR_WIDTH;
   localparam int BEAT_BYTES = C_M_AXI_DATA_WIDTH / 8;
   localparam int NBURSTS = FRAME_WORDS / C_M_AXI_BURST_LEN;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CHECK = 3'd1;
   localparam logic [2:0] S_ADDR  = 3'd2;
   localparam logic [2:0] S_DATA  = 3'd3;
   localparam logic [2:0] S_DRAIN = 3'd4;

   localparam logic [AW_-1:0] BASE = AW_'(C_M_TARGET_SLAVE_BASE_ADDR);
   localparam logic [AW_-1:0] BURST_BYTES =
      AW_'(C_M_AXI_BURST_LEN * BEAT_BYTES);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] BLEN_C = CW'(C_M_AXI_BURST_LEN);
   localparam logic [8:0] LAST_BEAT = 9'(C_M_AXI_BURST_LEN - 1);
   localparam logic [31:0] LAST_BURST = 32'(NBURSTS - 1);
   localparam logic [31:0] LAST_WORD = 32'(FRAME_WORDS - 1);
   localparam logic [2:0] SIZE_C = 3'($clog2(BEAT_BYTES));

   logic [2:0]    r_state;
   logic          r_busy;
   logic          r_done;
   logic          r_err;
   logic [AW_-1:0] r_araddr;
   logic [31:0]   r_burst;
   logic [8:0]    r_beat;
   // beats promised to the in-flight burst but not yet received
   logic [CW-1:0] r_resv;
   logic [CW-1:0] r_cnt;
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [31:0]   r_ocnt;
   logic [C_M_AXI_DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

   logic          w_push;
   logic          w_pop;
   logic          w_last;
   logic          w_eof;
   logic          w_valid;
   logic [CW-1:0] w_free;
   logic          w_unused;

   assign w_valid = (r_cnt != '0);
   assign w_push = (r_state == S_DATA) & bus.M_AXI_RVALID;
   assign w_pop = w_valid & bus.m_ready;
   // a missing or early RLAST still closes the burst on this beat
   assign w_last = w_push & (bus.M_AXI_RLAST | (r_beat == LAST_BEAT));
   assign w_eof = (r_ocnt == LAST_WORD);
   assign w_free = DEPTH_C - r_cnt - r_resv;
   assign w_unused = ^{bus.M_AXI_RID, bus.M_AXI_RUSER};

   assign bus.M_AXI_ARID    = '0;
   assign bus.M_AXI_ARADDR  = r_araddr;
   assign bus.M_AXI_ARLEN   = 8'(C_M_AXI_BURST_LEN - 1);
   assign bus.M_AXI_ARSIZE  = SIZE_C;
   assign bus.M_AXI_ARBURST = 2'b01;
   assign bus.M_AXI_ARLOCK  = 1'b0;
   assign bus.M_AXI_ARCACHE = 4'b0010;
   assign bus.M_AXI_ARPROT  = 3'b000;
   assign bus.M_AXI_ARQOS   = 4'b0000;
   assign bus.M_AXI_ARUSER  = '0;
   assign bus.M_AXI_ARVALID = (r_state == S_ADDR);
   assign bus.M_AXI_RREADY  = (r_state == S_DATA);

   assign bus.m_data  = r_mem[r_rptr];
   assign bus.m_valid = w_valid;
   assign bus.m_sof   = w_valid & (r_ocnt == '0);
   assign bus.m_eof   = w_valid & w_eof;

   assign busy = r_busy;
   assign done = r_done;
   assign err  = r_err;

   always_ff @(posedge M_AXI_ACLK) begin
      if (w_push) r_mem[r_wptr] <= bus.M_AXI_RDATA;
   end

   always_ff @(posedge M_AXI_ACLK) begin
      if (!M_AXI_ARESETN) begin
         r_state  <= S_IDLE;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_araddr <= BASE;
         r_burst  <= '0;
         r_beat   <= '0;
         r_resv   <= '0;
         r_cnt    <= '0;
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_ocnt   <= '0;
      end else begin
         r_done <= 1'b0;
         r_cnt  <= r_cnt + CW'(w_push) - CW'(w_pop);
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop) begin
            r_rptr <= r_rptr + PW'(1);
            r_ocnt <= w_eof ? '0 : r_ocnt + 32'd1;
         end
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_err    <= 1'b0;
                  r_araddr <= BASE;
                  r_burst  <= '0;
                  r_beat   <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (w_free >= BLEN_C) r_state <= S_ADDR;
            end
            S_ADDR: begin
               if (bus.M_AXI_ARREADY) begin
                  r_resv  <= BLEN_C;
                  r_state <= S_DATA;
               end
            end
            S_DATA: begin
               if (w_push) begin
                  if (bus.M_AXI_RRESP != 2'b00) r_err <= 1'b1;
                  if (bus.M_AXI_RLAST != (r_beat == LAST_BEAT))
                     r_err <= 1'b1;
                  if (w_last) begin
                     r_beat   <= '0;
                     r_resv   <= '0;
                     r_araddr <= r_araddr + BURST_BYTES;
                     r_burst  <= r_burst + 32'd1;
                     r_state  <= (r_burst == LAST_BURST) ? S_DRAIN : S_CHECK;
                  end else begin
                     r_beat <= r_beat + 9'd1;
                     r_resv <= r_resv - CW'(1);
                  end
               end
            end
            S_DRAIN: begin
               if (w_pop & w_eof) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule
